// File: rtl/life_pkg.sv
// Shared constants and the scanner state type for the 16x16 life array consumer.
package life_pkg;

   localparam int unsigned ROWS      = 16;
   localparam int unsigned ROW_W     = 16;
   localparam int unsigned ROW_IDX_W = 4;
   localparam int unsigned CNT_W     = 9;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      STEP,
      SEL,
      PRESENT,
      DONE
   } scan_state_t;

endpackage

// File: rtl/life_popcount16.sv
// Combinational population count of one 16-bit row.
module life_popcount16 (
   input  logic [15:0] data_i,
   output logic [4:0]  count_o
);

   // Sum the live bits of the row.
   always_comb begin
      count_o = '0;
      for (int i = 0; i < 16; i++) begin
         count_o = count_o + 5'(data_i[i]);
      end
   end

endmodule

// File: rtl/life_frame_scanner.sv
// Frame scanner for the 16x16 life array: walks valo_selector over every row, streams rows on a
// valid/ready port, totals the live cells per frame and paces generation steps between scans.
// Optional build macro LIFE_SCAN_CHANGE_EN adds row_changed / frame_stable outputs.
module life_frame_scanner
   import life_pkg::*;
#(
   parameter int unsigned GEN_DIV = 1000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic                 single_step,
   input  logic [ROW_W-1:0]     valo,
   input  logic [ROW_W-1:0]     valo_prev,
   output logic [ROW_IDX_W-1:0] valo_selector,
   output logic                 step,
   output logic [ROW_W-1:0]     row_data,
   output logic [ROW_IDX_W-1:0] row_index,
   output logic                 row_valid,
   input  logic                 row_ready,
   output logic                 frame_done,
   output logic [CNT_W-1:0]     alive_count,
   output logic                 busy
`ifdef LIFE_SCAN_CHANGE_EN
   ,
   output logic [ROW_W-1:0]     row_changed,
   output logic                 frame_stable
`endif
);

   localparam int unsigned DivW = (GEN_DIV > 1) ? $clog2(GEN_DIV) : 1;

   scan_state_t          state_q, state_d;
   logic [ROW_IDX_W-1:0] row_q, row_d;
   logic [ROW_W-1:0]     data_q, data_d;
   logic [CNT_W-1:0]     acc_q, acc_d;
   logic [CNT_W-1:0]     alive_q, alive_d;
   logic                 pend_q, pend_d;
   logic [DivW-1:0]      cnt_q, cnt_d;
   logic [4:0]           pop;
   logic                 handshake;

   life_popcount16 u_popcount (
      .data_i  (data_q),
      .count_o (pop)
   );

   assign valo_selector = row_q;
   assign row_data      = data_q;
   assign row_index     = row_q;
   assign row_valid     = (state_q == PRESENT);
   assign step          = (state_q == STEP);
   assign frame_done    = (state_q == DONE);
   assign busy          = (state_q != IDLE);
   assign alive_count   = alive_q;
   assign handshake     = row_valid & row_ready;

   // Scanner state and counters; reset starts an unstepped scan of the preloaded array.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SEL;
         row_q   <= '0;
         data_q  <= '0;
         acc_q   <= '0;
         alive_q <= '0;
         pend_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         data_q  <= data_d;
         acc_q   <= acc_d;
         alive_q <= alive_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: row walk, handshake, population total and generation pacing.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      data_d  = data_q;
      acc_d   = acc_q;
      alive_d = alive_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;

      // A request arriving mid-scan is remembered and served at the next IDLE.
      if (single_step && (state_q != IDLE) && (state_q != WAIT)) begin
         pend_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (pend_q || single_step) begin
               state_d = STEP;
               pend_d  = 1'b0;
            end else if (run) begin
               state_d = WAIT;
               cnt_d   = DivW'(GEN_DIV - 1);
            end
         end
         WAIT: begin
            if (single_step) begin
               state_d = STEP;
            end else if (!run) begin
               state_d = IDLE;
            end else if (cnt_q <= DivW'(1)) begin
               // Counter reaches zero on this decrement, so the step follows directly.
               state_d = STEP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - DivW'(1);
            end
         end
         STEP: begin
            state_d = SEL;
            row_d   = '0;
         end
         SEL: begin
            data_d  = valo;
            state_d = PRESENT;
         end
         PRESENT: begin
            if (handshake) begin
               acc_d = acc_q + CNT_W'(pop);
               if (row_q == ROW_IDX_W'(ROWS - 1)) begin
                  state_d = DONE;
               end else begin
                  row_d   = row_q + ROW_IDX_W'(1);
                  state_d = SEL;
               end
            end
         end
         DONE: begin
            alive_d = acc_q;
            acc_d   = '0;
            row_d   = '0;
            state_d = IDLE;
         end
         default: begin
            state_d = SEL;
            row_d   = '0;
         end
      endcase
   end

`ifdef LIFE_SCAN_CHANGE_EN
   logic [ROW_W-1:0] chg_q, chg_d;
   logic             any_q, any_d;
   logic             stable_q, stable_d;

   assign row_changed  = row_valid ? chg_q : '0;
   assign frame_stable = stable_q;

   // Change tracking registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         chg_q    <= '0;
         any_q    <= 1'b0;
         stable_q <= 1'b0;
      end else begin
         chg_q    <= chg_d;
         any_q    <= any_d;
         stable_q <= stable_d;
      end
   end

   // Capture per-row differences with the row and fold them into a frame verdict at DONE.
   always_comb begin
      chg_d    = chg_q;
      any_d    = any_q;
      stable_d = stable_q;
      if (state_q == SEL) begin
         chg_d = valo ^ valo_prev;
      end
      if (handshake && (chg_q != '0)) begin
         any_d = 1'b1;
      end
      if (state_q == DONE) begin
         stable_d = ~any_q;
         any_d    = 1'b0;
      end
   end
`else
   // Previous-generation row only matters for change tracking.
   logic unused_valo_prev;
   assign unused_valo_prev = ^valo_prev;
`endif

endmodule
